// File: rtl/xor_descrambler_if.sv
// Valid/ready beat channel with a start-of-frame flag.
interface xor_descrambler_if #(
    parameter int unsigned N = 8
) ();
    logic         valid;
    logic         ready;
    logic [N-1:0] data;
    logic         sof;

    modport master (output valid, output data, output sof, input ready);
    modport slave  (input valid, input data, input sof, output ready);
endinterface

// File: rtl/xor_descrambler.sv
// Word-parallel additive descrambler, x^7 + x^6 + 1 keystream, one-beat output register.
module xor_descrambler #(
    parameter int unsigned N    = 8,
    parameter logic [6:0]  SEED = 7'h7F,
    parameter int unsigned CW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    xor_descrambler_if.slave      s,
    xor_descrambler_if.master     m,
    output logic [CW-1:0]         beat_cnt
);

    localparam int unsigned LW = 7;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [LW-1:0] lfsr_q, lfsr_d;
    logic          m_valid_q, m_valid_d;
    logic [N-1:0]  m_data_q, m_data_d;
    logic          m_sof_q, m_sof_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          emit;
    logic [LW-1:0] lfsr_start;
    logic [LW-1:0] lfsr_stepped;
    logic [N-1:0]  keystream;

    assign s.ready = !m_valid_q || m.ready;
    assign accept  = s.valid && s.ready;
    assign emit    = m_valid_q && m.ready;

    // Run the LFSR N steps from the frame seed or the running state.
    always_comb begin
        logic [LW-1:0] st;
        logic          fb;
        lfsr_start = s.sof ? SEED : lfsr_q;
        st         = lfsr_start;
        fb         = 1'b0;
        keystream  = '0;
        for (int k = 0; k < N; k++) begin
            fb           = st[6] ^ st[5];
            keystream[k] = fb;
            st           = {st[5:0], fb};
        end
        lfsr_stepped = st;
    end

    // Next state for output stage, LFSR and frame counter.
    always_comb begin
        lfsr_d    = lfsr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sof_d   = m_sof_q;
        cnt_d     = cnt_q;
        if (emit) begin
            m_valid_d = 1'b0;
        end
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = en ? (s.data ^ keystream) : s.data;
            m_sof_d   = s.sof;
            // Bypass with sof still re-seeds, but takes no steps.
            lfsr_d    = en ? lfsr_stepped : lfsr_start;
            if (s.sof) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= SEED;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sof_q   <= m_sof_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m.valid  = m_valid_q;
    assign m.data   = m_data_q;
    assign m.sof    = m_sof_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed and randomized-backpressure bench for xor_descrambler.
module tb_xor_descrambler;

    localparam int unsigned N    = 8;
    localparam int unsigned CW   = 16;
    localparam int unsigned CW2  = 2;
    localparam logic [6:0]  SEED = 7'h7F;
    localparam int          NBEATS = 1000;
    localparam int          BUDGET = 20000;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    xor_descrambler_if #(.N(N)) s_if ();
    xor_descrambler_if #(.N(N)) m_if ();
    xor_descrambler_if #(.N(N)) s2_if ();
    xor_descrambler_if #(.N(N)) m2_if ();

    logic [CW-1:0]  beat_cnt;
    logic [CW2-1:0] beat_cnt2;

    assign s2_if.valid = s_if.valid;
    assign s2_if.data  = s_if.data;
    assign s2_if.sof   = s_if.sof;
    assign m2_if.ready = m_if.ready;

    xor_descrambler #(.N(N), .SEED(SEED), .CW(CW)) u_dut (
        .clk(clk), .rst(rst), .en(en), .s(s_if.slave), .m(m_if.master), .beat_cnt(beat_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, to exercise saturation.
    xor_descrambler #(.N(N), .SEED(SEED), .CW(CW2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .s(s2_if.slave), .m(m2_if.master), .beat_cnt(beat_cnt2)
    );

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference scrambler: returns {next_state, keystream} for one 8-bit beat.
    function automatic logic [14:0] scr(input logic [6:0] s0);
        logic [6:0] s;
        logic [7:0] ks;
        logic       b;
        s  = s0;
        ks = '0;
        for (int k = 0; k < 8; k++) begin
            b     = s[6] ^ s[5];
            ks[k] = b;
            s     = {s[5:0], b};
        end
        return {s, ks};
    endfunction

    task automatic beat(input logic [7:0] d, input logic sof, input logic e);
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.sof   = sof;
        en         = e;
        tick();
        s_if.valid = 1'b0;
    endtask

    logic [6:0]  mdl;
    logic [14:0] r;
    logic [7:0]  pt;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_d;
    logic        acc, emt;
    int          sent, cyc;

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.sof   = 1'b0;
        m_if.ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check("rst_m_valid", 32'(m_if.valid), 32'h0);
        check("rst_m_data", 32'(m_if.data), 32'h0);
        check("rst_m_sof", 32'(m_if.sof), 32'h0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'h0);
        check("rst_s_ready", 32'(s_if.ready), 32'h1);
        rst = 1'b0;

        // Frame start and continuation; keystreams 0x40, 0x30, 0x14 from seed 7F.
        beat(8'h40, 1'b1, 1'b1);
        check("b1_valid", 32'(m_if.valid), 32'h1);
        check("b1_data", 32'(m_if.data), 32'h00);
        check("b1_sof", 32'(m_if.sof), 32'h1);
        check("b1_cnt", 32'(beat_cnt), 32'd1);
        beat(8'h30, 1'b0, 1'b1);
        check("b2_data", 32'(m_if.data), 32'h00);
        check("b2_sof", 32'(m_if.sof), 32'h0);
        check("b2_cnt", 32'(beat_cnt), 32'd2);
        beat(8'hA5, 1'b0, 1'b1);
        check("b3_data", 32'(m_if.data), 32'hB1);
        check("b3_cnt", 32'(beat_cnt), 32'd3);
        beat(8'h40, 1'b1, 1'b1);
        check("b4_data", 32'(m_if.data), 32'h00);
        check("b4_sof", 32'(m_if.sof), 32'h1);
        check("b4_cnt", 32'(beat_cnt), 32'd1);

        // Backpressure: output holds, nothing accepted, LFSR frozen at 0x02.
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 8'h31;
        s_if.sof   = 1'b0;
        #1;
        check("hold_s_ready0", 32'(s_if.ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(m_if.valid), 32'h1);
            check("hold_data", 32'(m_if.data), 32'h00);
            check("hold_sof", 32'(m_if.sof), 32'h1);
            check("hold_cnt", 32'(beat_cnt), 32'd1);
        end
        m_if.ready = 1'b1;
        #1;
        check("release_s_ready", 32'(s_if.ready), 32'h1);
        tick();
        s_if.valid = 1'b0;
        check("release_data", 32'(m_if.data), 32'h01);
        check("release_cnt", 32'(beat_cnt), 32'd2);

        // Bypass then resume: keystream after the bypass is still 0x14.
        beat(8'h5A, 1'b0, 1'b0);
        check("bypass_data", 32'(m_if.data), 32'h5A);
        check("bypass_cnt", 32'(beat_cnt), 32'd3);
        beat(8'hA5, 1'b0, 1'b1);
        check("resume_data", 32'(m_if.data), 32'hB1);
        check("resume_cnt", 32'(beat_cnt), 32'd4);
        check("sat_cnt_dir", 32'(beat_cnt2), 32'd3);

        // Bypass with sof re-seeds without stepping.
        beat(8'h77, 1'b1, 1'b0);
        check("bypass_sof_data", 32'(m_if.data), 32'h77);
        check("bypass_sof_cnt", 32'(beat_cnt), 32'd1);
        beat(8'h40, 1'b0, 1'b1);
        check("after_reseed_data", 32'(m_if.data), 32'h00);
        check("after_reseed_cnt", 32'(beat_cnt), 32'd2);

        // Emit with no accept clears the output stage.
        tick();
        check("drain_valid", 32'(m_if.valid), 32'h0);

        // Randomized valid/backpressure over one scrambled frame.
        mdl  = SEED;
        sent = 0;
        cyc  = 0;
        pt   = 8'($urandom);
        while ((sent < NBEATS || exp_q.size() != 0) && cyc < BUDGET) begin
            if (sent < NBEATS) begin
                r          = scr((sent == 0) ? SEED : mdl);
                s_if.valid = ($urandom_range(0, 3) != 0);
                s_if.sof   = (sent == 0);
                s_if.data  = pt ^ r[7:0];
            end else begin
                s_if.valid = 1'b0;
            end
            m_if.ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = s_if.valid && s_if.ready;
            emt = m_if.valid && m_if.ready;
            if (emt) begin
                check("rand_not_spurious", 32'(exp_q.size() != 0), 32'h1);
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                check("rand_data", 32'(m_if.data), 32'(exp_d));
            end
            if (acc) begin
                exp_q.push_back(pt);
                mdl = r[14:8];
                sent++;
                pt = 8'($urandom);
            end
            tick();
            cyc++;
        end
        s_if.valid = 1'b0;
        check("rand_in_budget", 32'(cyc < BUDGET), 32'h1);
        check("rand_cnt", 32'(beat_cnt), 32'(NBEATS));
        check("sat_cnt_rand", 32'(beat_cnt2), 32'd3);

        // Back-to-back throughput with the consumer always ready.
        m_if.ready = 1'b1;
        s_if.sof   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r          = scr(mdl);
            s_if.valid = 1'b1;
            s_if.data  = pt ^ r[7:0];
            #1;
            check("tput_s_ready", 32'(s_if.ready), 32'h1);
            tick();
            mdl = r[14:8];
            check("tput_valid", 32'(m_if.valid), 32'h1);
            check("tput_data", 32'(m_if.data), 32'(pt));
            pt = 8'($urandom);
        end
        check("tput_cnt", 32'(beat_cnt), 32'(NBEATS + 8));

        // Reset mid-frame with a held output beat.
        m_if.ready = 1'b0;
        s_if.data  = 8'h12;
        tick();
        check("pre_rst_valid", 32'(m_if.valid), 32'h1);
        rst        = 1'b1;
        s_if.valid = 1'b0;
        tick();
        check("midrst_valid", 32'(m_if.valid), 32'h0);
        check("midrst_cnt", 32'(beat_cnt), 32'h0);
        check("midrst_data", 32'(m_if.data), 32'h0);
        rst        = 1'b0;
        m_if.ready = 1'b1;
        beat(8'h40, 1'b0, 1'b1);
        check("postrst_data", 32'(m_if.data), 32'h00);
        check("postrst_sof", 32'(m_if.sof), 32'h0);
        check("postrst_cnt", 32'(beat_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
